// File: rtl/bus_pkg.sv
// Shared bus definitions for the run/done toggle bus: command encoding,
// memory FSM states and a small index-width helper.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_CMD_NOP   = 2'd0,
    BUS_CMD_READ  = 2'd1,
    BUS_CMD_WRITE = 2'd2
  } bus_cmd_t;

  typedef enum logic [0:0] {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_t;

  localparam int BUS_MAX_WAIT = 15;

  // Width of an index into n items; never zero so single-item cases still get a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping. The pointer itself is owned by the caller.
module bus_rr_arb
  import bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [2*N-1:0] dbl_s;

  // Rotate the doubled request vector so bit k is port (ptr+k) mod N, keep first hit.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      gnt_idx = (dbl_s[k] && !gnt_vld) ? PW'((int'(ptr) + k) % N) : gnt_idx;
      gnt_vld = gnt_vld | dbl_s[k];
    end
  end

endmodule

// File: rtl/bus_mem_mp.sv
// Multi-port word memory on the run/done toggle bus with round-robin service.
// Optional macro BUS_MEM_ERR_EN: out-of-range accesses are suppressed and flagged on err.
module bus_mem_mp
  import bus_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH       = 32768,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*2-1:0]  cmd,
  input  logic [NPORTS-1:0]    run,
  input  logic [NPORTS*DW-1:0] wr_data,
  output logic [NPORTS*DW-1:0] rd_data,
  output logic [NPORTS-1:0]    done,
  output logic [NPORTS-1:0]    err
);

  localparam int PW = idx_width(NPORTS);
  localparam int LW = idx_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  mem_state_t           state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NPORTS-1:0]    done_q, done_d;
  logic [NPORTS-1:0]    err_q, err_d;
  logic [NPORTS*DW-1:0] rd_data_q, rd_data_d;

  logic [NPORTS-1:0]    pending_s;
  logic [PW-1:0]        arb_idx_s;
  logic                 arb_vld_s;
  logic [LW-1:0]        mem_idx_s;
  logic [DW-1:0]        mem_rdata_s;
  logic                 in_range_s;
  logic                 mem_we_s;
  logic                 unused_s;

  assign pending_s   = run ^ done_q;
  assign mem_idx_s   = addr_q[LW-1:0];
  assign mem_rdata_s = mem[mem_idx_s];
  assign unused_s    = ^addr_q;

`ifdef BUS_MEM_ERR_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign in_range_s = ({1'b0, addr_q} < DEPTH_W);
`else
  // Upper address bits are dropped, so out-of-range addresses alias into the array.
  assign in_range_s = 1'b1;
`endif

  bus_rr_arb #(
    .N  (NPORTS),
    .PW (PW)
  ) u_arb (
    .req     (pending_s),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // Grant / wait / complete sequencing and all next-state values.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    mem_we_s  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (arb_vld_s) begin
          gnt_d   = arb_idx_s;
          addr_d  = addr[arb_idx_s*AW +: AW];
          cmd_d   = cmd[arb_idx_s*2 +: 2];
          wdata_d = wr_data[arb_idx_s*DW +: DW];
          cnt_d   = 4'(WAIT_STATES);
          state_d = MEM_ACCESS;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done_d[gnt_q] = ~done_q[gnt_q];
          err_d[gnt_q]  = ~in_range_s;
          rr_ptr_d      = (gnt_q == PW'(NPORTS - 1)) ? PW'(0) : gnt_q + PW'(1);
          if (in_range_s && (cmd_q == BUS_CMD_READ)) begin
            rd_data_d[gnt_q*DW +: DW] = mem_rdata_s;
          end else begin
            rd_data_d = rd_data_q;
          end
          // A reset landing on the completion edge must not commit the write.
          mem_we_s = in_range_s && (cmd_q == BUS_CMD_WRITE) && !reset;
          state_d  = MEM_IDLE;
        end
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  // Control and datapath registers; memory contents survive reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= MEM_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      cmd_q     <= 2'd0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      done_q    <= '0;
      err_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Single write port into the inferred storage array.
  always_ff @(posedge sysclk) begin
    if (mem_we_s) begin
      mem[mem_idx_s] <= wdata_q;
    end
  end

  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
